decoder_unit_pipe: RTL and testbench

DECODER_UNIT_PIPE -- requirements
Module: decoder_unit_pipe

---
 rtl/decoder_unit_pipe_if.sv | 45 ++++
 rtl/decoder_unit_pipe.sv | 195 +++++++++++++++++++
 tb/tb_decoder_unit_pipe.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_unit_pipe_if.sv
// Decoder handshake bundle: upstream instruction/regfile side plus downstream decoded-bundle side.
// slave = decoder view, master = environment view.
interface decoder_unit_pipe_if #(
  parameter int XLEN  = 64,
  parameter int PID_W = 2
);
  logic              flush_i;
  logic              valid_i;
  logic              ready_o;
  logic [PID_W-1:0]  pID_i;
  logic [31:0]       inst_i;
  logic [4:0]        rs1Addr_o;
  logic [4:0]        rs2Addr_o;
  logic              rs1ReadEnable_o;
  logic              rs2ReadEnable_o;
  logic [XLEN-1:0]   rs1ReadData_i;
  logic [XLEN-1:0]   rs2ReadData_i;
  logic              valid_o;
  logic              ready_i;
  logic [4:0]        rdAddr_o;
  logic              rdWriteEnable_o;
  logic [XLEN-1:0]   rs1ReadData_o;
  logic [XLEN-1:0]   rs2ReadData_o;
  logic [XLEN-1:0]   imm_o;
  logic [6:0]        opCode_o;
  logic [2:0]        funct3_o;
  logic [6:0]        funct7_o;
  logic [5:0]        shamt_o;
  logic              illegal_o;
  logic [PID_W-1:0]  pID_o;

  modport slave (
    input  flush_i, valid_i, pID_i, inst_i, rs1ReadData_i, rs2ReadData_i, ready_i,
    output ready_o, rs1Addr_o, rs2Addr_o, rs1ReadEnable_o, rs2ReadEnable_o,
           valid_o, rdAddr_o, rdWriteEnable_o, rs1ReadData_o, rs2ReadData_o, imm_o,
           opCode_o, funct3_o, funct7_o, shamt_o, illegal_o, pID_o
  );

  modport master (
    output flush_i, valid_i, pID_i, inst_i, rs1ReadData_i, rs2ReadData_i, ready_i,
    input  ready_o, rs1Addr_o, rs2Addr_o, rs1ReadEnable_o, rs2ReadEnable_o,
           valid_o, rdAddr_o, rdWriteEnable_o, rs1ReadData_o, rs2ReadData_o, imm_o,
           opCode_o, funct3_o, funct7_o, shamt_o, illegal_o, pID_o
  );
endinterface

// File: rtl/decoder_unit_pipe.sv
// RISC-V decode stage: combinational regfile addressing, 1-cycle registered bundle out.
// Main+skid register pair; ready_o is registered (!skid valid), so no path from ready_i.
module decoder_unit_pipe #(
  parameter int XLEN    = 64,
  parameter int PID_W   = 2,
  parameter bit RV64_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  decoder_unit_pipe_if.slave bus
);

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_AMO       = 7'b0101111;
  localparam logic [6:0] OPC_OP_FP     = 7'b1010011;

  typedef struct packed {
    logic [4:0]       rd_addr;
    logic             rd_we;
    logic [XLEN-1:0]  rs1_dat;
    logic [XLEN-1:0]  rs2_dat;
    logic [XLEN-1:0]  imm;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [5:0]       shamt;
    logic             illegal;
    logic [PID_W-1:0] pid;
  } bundle_t;

  logic [31:0]     inst;
  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign inst  = bus.inst_i;
  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_u = {{(XLEN-20){inst[31]}}, inst[31:12]};

  logic            legal, rs1_en, rs2_en, rd_cls, rd_wr, sys_rw, is_shift;
  logic [XLEN-1:0] imm_dec;
  logic [5:0]      shamt_dec;

  always_comb begin
    legal     = 1'b0;
    rs1_en    = 1'b0;
    rs2_en    = 1'b0;
    rd_cls    = 1'b0;
    rd_wr     = 1'b0;
    imm_dec   = '0;
    shamt_dec = '0;
    // CSR forms that read rs1 and write rd; ECALL/EBREAK-style funct3 000/100 do neither
    sys_rw    = (f3 != 3'b000) && (f3 != 3'b100);
    is_shift  = ((f3 == 3'b001) && (inst[31:26] == 6'b000000)) ||
                ((f3 == 3'b101) && ((inst[31:26] == 6'b000000) || (inst[31:26] == 6'b010000)));
    if (inst[1:0] == 2'b11) begin
      case (opc)
        OPC_LUI, OPC_AUIPC: begin legal = 1'b1; rd_cls = 1'b1; rd_wr = 1'b1; imm_dec = imm_u; end
        OPC_JAL:    begin legal = 1'b1; rd_cls = 1'b1; rd_wr = 1'b1; imm_dec = imm_j; end
        OPC_JALR:   begin legal = 1'b1; rs1_en = 1'b1; rd_cls = 1'b1; rd_wr = 1'b1; imm_dec = imm_i; end
        OPC_BRANCH: begin legal = 1'b1; rs1_en = 1'b1; rs2_en = 1'b1; imm_dec = imm_b; end
        OPC_LOAD:   begin legal = 1'b1; rs1_en = 1'b1; imm_dec = imm_i; end
        OPC_STORE:  begin legal = 1'b1; rs1_en = 1'b1; rs2_en = 1'b1; imm_dec = imm_s; end
        OPC_OP_IMM: begin
          legal = 1'b1; rs1_en = 1'b1; rd_cls = 1'b1; rd_wr = 1'b1; imm_dec = imm_i;
          if (is_shift) begin
            shamt_dec = inst[25:20];
            if ((XLEN == 32) && inst[25]) legal = 1'b0;
          end
        end
        // M-extension results come back through the multiplier's own write port
        OPC_OP:     begin legal = 1'b1; rs1_en = 1'b1; rs2_en = 1'b1; rd_cls = 1'b1; rd_wr = (f7 != 7'b0000001); end
        OPC_SYSTEM: begin legal = 1'b1; rs1_en = sys_rw; rd_cls = sys_rw; rd_wr = sys_rw; imm_dec = imm_i; end
        OPC_OP_IMM_32: begin legal = RV64_EN; rs1_en = 1'b1; rd_cls = 1'b1; rd_wr = 1'b1; imm_dec = imm_i; end
        OPC_OP_32:  begin legal = RV64_EN; rs1_en = 1'b1; rs2_en = 1'b1; rd_cls = 1'b1; rd_wr = (f7 != 7'b0000001); end
        OPC_AMO, OPC_OP_FP: begin legal = 1'b1; rs1_en = 1'b1; rs2_en = 1'b1; rd_cls = 1'b1; rd_wr = 1'b1; end
        default: ;
      endcase
    end
    if (!legal) begin
      rs1_en    = 1'b0;
      rs2_en    = 1'b0;
      rd_cls    = 1'b0;
      rd_wr     = 1'b0;
      imm_dec   = '0;
      shamt_dec = '0;
    end
  end

  logic [4:0] rd_addr;
  assign rd_addr             = rd_cls ? inst[11:7] : 5'd0;
  assign bus.rs1ReadEnable_o = rs1_en;
  assign bus.rs2ReadEnable_o = rs2_en;
  assign bus.rs1Addr_o       = rs1_en ? inst[19:15] : 5'd0;
  assign bus.rs2Addr_o       = rs2_en ? inst[24:20] : 5'd0;

  bundle_t dec_b;
  always_comb begin
    dec_b         = '0;
    dec_b.rd_addr = rd_addr;
    dec_b.rd_we   = rd_wr && (rd_addr != 5'd0);
    dec_b.rs1_dat = bus.rs1ReadData_i;
    dec_b.rs2_dat = bus.rs2ReadData_i;
    dec_b.imm     = imm_dec;
    dec_b.opcode  = opc;
    dec_b.funct3  = f3;
    dec_b.funct7  = f7;
    dec_b.shamt   = shamt_dec;
    dec_b.illegal = !legal;
    dec_b.pid     = bus.pID_i;
  end

  bundle_t m_q, m_d, s_q, s_d;
  logic    m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  logic    acc, fire;

  assign acc  = bus.valid_i && !s_vld_q;
  assign fire = m_vld_q && bus.ready_i;

  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    if (bus.flush_i) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (fire) begin
      if (s_vld_q) begin
        m_d     = s_q;
        m_vld_d = 1'b1;
        s_vld_d = acc;
        if (acc) s_d = dec_b;
      end else begin
        m_vld_d = acc;
        if (acc) m_d = dec_b;
      end
    end else if (acc) begin
      if (!m_vld_q) begin
        m_d     = dec_b;
        m_vld_d = 1'b1;
      end else begin
        s_d     = dec_b;
        s_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  assign bus.ready_o         = !s_vld_q;
  assign bus.valid_o         = m_vld_q;
  assign bus.rdAddr_o        = m_q.rd_addr;
  assign bus.rdWriteEnable_o = m_q.rd_we;
  assign bus.rs1ReadData_o   = m_q.rs1_dat;
  assign bus.rs2ReadData_o   = m_q.rs2_dat;
  assign bus.imm_o           = m_q.imm;
  assign bus.opCode_o        = m_q.opcode;
  assign bus.funct3_o        = m_q.funct3;
  assign bus.funct7_o        = m_q.funct7;
  assign bus.shamt_o         = m_q.shamt;
  assign bus.illegal_o       = m_q.illegal;
  assign bus.pID_o           = m_q.pid;

endmodule

// File: tb/tb_decoder_unit_pipe.sv
// Scoreboard bench for decoder_unit_pipe: RV64 instance for decode/flow control, RV32 no-RV64 instance for width-dependent legality.
module tb_decoder_unit_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decoder_unit_pipe_if #(.XLEN(64), .PID_W(2)) b64 ();
  decoder_unit_pipe_if #(.XLEN(32), .PID_W(2)) b32 ();

  decoder_unit_pipe #(.XLEN(64), .PID_W(2), .RV64_EN(1'b1)) dut   (.clk(clk), .rst(rst), .bus(b64.slave));
  decoder_unit_pipe #(.XLEN(32), .PID_W(2), .RV64_EN(1'b0)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));

  typedef struct {
    logic [31:0] inst;
    logic        r1e;
    logic [4:0]  r1a;
    logic        r2e;
    logic [4:0]  r2a;
    logic [4:0]  rd;
    logic        we;
    logic [63:0] imm;
    logic [5:0]  sh;
    logic        il;
    logic [1:0]  pid;
    logic [63:0] d1;
    logic [63:0] d2;
  } ent_t;

  ent_t vt[15];
  ent_t wt[5];
  ent_t q64[$];
  ent_t q32[$];
  int   pop64[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic ent_t mk(input logic [31:0] inst, input logic r1e, input logic [4:0] r1a,
                              input logic r2e, input logic [4:0] r2a, input logic [4:0] rd,
                              input logic we, input logic [63:0] imm, input logic [5:0] sh, input logic il);
    ent_t e;
    e.inst = inst; e.r1e = r1e; e.r1a = r1a; e.r2e = r2e; e.r2a = r2a;
    e.rd = rd; e.we = we; e.imm = imm; e.sh = sh; e.il = il;
    e.pid = 2'd0; e.d1 = '0; e.d2 = '0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cmp(input string tag, input ent_t e, input logic [63:0] mask,
                     input logic [4:0] rd, input logic we, input logic [63:0] imm,
                     input logic [63:0] d1, input logic [63:0] d2, input logic [6:0] op,
                     input logic [2:0] f3, input logic [6:0] f7, input logic [5:0] sh,
                     input logic il, input logic [1:0] pid);
    logic [31:0] i;
    i = e.inst;
    chk({tag, ".rd"}, rd, e.rd);
    chk({tag, ".we"}, we, e.we);
    chk({tag, ".imm"}, imm & mask, e.imm & mask);
    chk({tag, ".rs1d"}, d1 & mask, e.d1 & mask);
    chk({tag, ".rs2d"}, d2 & mask, e.d2 & mask);
    chk({tag, ".op"}, op, i[6:0]);
    chk({tag, ".f3"}, f3, i[14:12]);
    chk({tag, ".f7"}, f7, i[31:25]);
    chk({tag, ".shamt"}, sh, e.sh);
    chk({tag, ".illegal"}, il, e.il);
    chk({tag, ".pid"}, pid, e.pid);
  endtask

  // Monitors: pop the oldest expectation whenever a bundle is handed downstream
  always @(negedge clk) begin
    ent_t e;
    if (rst && b64.valid_o && b64.ready_i) begin
      if (q64.size() == 0) chk("out64_unexpected", 1, 0);
      else begin
        e = q64.pop_front();
        pop64.push_back(cyc);
        cmp($sformatf("out64_%08h", e.inst), e, 64'hFFFF_FFFF_FFFF_FFFF, b64.rdAddr_o, b64.rdWriteEnable_o,
            b64.imm_o, b64.rs1ReadData_o, b64.rs2ReadData_o, b64.opCode_o, b64.funct3_o,
            b64.funct7_o, b64.shamt_o, b64.illegal_o, b64.pID_o);
      end
    end
  end

  always @(negedge clk) begin
    ent_t e;
    if (rst && b32.valid_o && b32.ready_i) begin
      if (q32.size() == 0) chk("out32_unexpected", 1, 0);
      else begin
        e = q32.pop_front();
        cmp($sformatf("out32_%08h", e.inst), e, 64'h0000_0000_FFFF_FFFF, b32.rdAddr_o, b32.rdWriteEnable_o,
            {32'd0, b32.imm_o}, {32'd0, b32.rs1ReadData_o}, {32'd0, b32.rs2ReadData_o}, b32.opCode_o,
            b32.funct3_o, b32.funct7_o, b32.shamt_o, b32.illegal_o, b32.pID_o);
      end
    end
  end

  // Present one instruction, wait (bounded) for acceptance, check the same-cycle read ports
  task automatic issue64(input ent_t v, input logic [1:0] pid);
    ent_t e;
    int   t;
    e = v; e.pid = pid; e.d1 = {$urandom, $urandom}; e.d2 = {$urandom, $urandom};
    b64.valid_i = 1'b1; b64.inst_i = v.inst; b64.pID_i = pid;
    b64.rs1ReadData_i = e.d1; b64.rs2ReadData_i = e.d2;
    @(negedge clk);
    t = 0;
    while (!b64.ready_o && t < 40) begin @(negedge clk); t++; end
    chk("accept64_wait", b64.ready_o, 1);
    chk($sformatf("comb64_%08h.r1e", v.inst), b64.rs1ReadEnable_o, v.r1e);
    chk($sformatf("comb64_%08h.r1a", v.inst), b64.rs1Addr_o, v.r1a);
    chk($sformatf("comb64_%08h.r2e", v.inst), b64.rs2ReadEnable_o, v.r2e);
    chk($sformatf("comb64_%08h.r2a", v.inst), b64.rs2Addr_o, v.r2a);
    if (b64.ready_o) q64.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic issue32(input ent_t v, input logic [1:0] pid);
    ent_t e;
    int   t;
    e = v; e.pid = pid; e.d1 = {32'd0, $urandom}; e.d2 = {32'd0, $urandom};
    b32.valid_i = 1'b1; b32.inst_i = v.inst; b32.pID_i = pid;
    b32.rs1ReadData_i = e.d1[31:0]; b32.rs2ReadData_i = e.d2[31:0];
    @(negedge clk);
    t = 0;
    while (!b32.ready_o && t < 40) begin @(negedge clk); t++; end
    chk("accept32_wait", b32.ready_o, 1);
    chk($sformatf("comb32_%08h.r1e", v.inst), b32.rs1ReadEnable_o, v.r1e);
    chk($sformatf("comb32_%08h.r1a", v.inst), b32.rs1Addr_o, v.r1a);
    chk($sformatf("comb32_%08h.r2e", v.inst), b32.rs2ReadEnable_o, v.r2e);
    if (b32.ready_o) q32.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: sim time %0t exceeded, want finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t;
    //            inst           r1e r1a r2e r2a rd we imm                     sh  il
    vt[0]  = mk(32'hFFF08293, 1, 1, 0, 0, 5, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0,  0); // addi x5,x1,-1
    vt[1]  = mk(32'h00008067, 1, 1, 0, 0, 0, 0, 64'h0,                   0,  0); // jalr x0,0(x1)
    vt[2]  = mk(32'h022081B3, 1, 1, 1, 2, 3, 0, 64'h0,                   0,  0); // mul x3,x1,x2
    vt[3]  = mk(32'h02009093, 1, 1, 0, 0, 1, 1, 64'd32,                  32, 0); // slli x1,x1,32
    vt[4]  = mk(32'h800003B7, 0, 0, 0, 0, 7, 1, 64'hFFFF_FFFF_FFF8_0000, 0,  0); // lui x7,0x80000
    vt[5]  = mk(32'hFE20AE23, 1, 1, 1, 2, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0,  0); // sw x2,-4(x1)
    vt[6]  = mk(32'hFE208CE3, 1, 1, 1, 2, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0,  0); // beq x1,x2,-8
    vt[7]  = mk(32'h001000EF, 0, 0, 0, 0, 1, 1, 64'h800,                 0,  0); // jal x1,+2048
    vt[8]  = mk(32'h300091F3, 1, 1, 0, 0, 3, 1, 64'h300,                 0,  0); // csrrw x3,0x300,x1
    vt[9]  = mk(32'h00000073, 0, 0, 0, 0, 0, 0, 64'h0,                   0,  0); // ecall
    vt[10] = mk(32'h0000000B, 0, 0, 0, 0, 0, 0, 64'h0,                   0,  1); // custom-0
    vt[11] = mk(32'hFFF08290, 0, 0, 0, 0, 0, 0, 64'h0,                   0,  1); // low bits 00
    vt[12] = mk(32'h43F0D213, 1, 1, 0, 0, 4, 1, 64'h43F,                 63, 0); // srai x4,x1,63
    vt[13] = mk(32'h0010831B, 1, 1, 0, 0, 6, 1, 64'h1,                   0,  0); // addiw x6,x1,1
    vt[14] = mk(32'h00208033, 1, 1, 1, 2, 0, 0, 64'h0,                   0,  0); // add x0,x1,x2
    wt[0]  = mk(32'h02009093, 0, 0, 0, 0, 0, 0, 64'h0,                   0,  1); // slli 32 on RV32
    wt[1]  = mk(32'h0010831B, 0, 0, 0, 0, 0, 0, 64'h0,                   0,  1); // addiw, RV64 off
    wt[2]  = vt[0];
    wt[3]  = mk(32'h01F09093, 1, 1, 0, 0, 1, 1, 64'd31,                  31, 0); // slli x1,x1,31
    wt[4]  = vt[4];

    b64.flush_i = 0; b64.valid_i = 0; b64.ready_i = 1; b64.inst_i = '0; b64.pID_i = '0;
    b64.rs1ReadData_i = '0; b64.rs2ReadData_i = '0;
    b32.flush_i = 0; b32.valid_i = 0; b32.ready_i = 1; b32.inst_i = '0; b32.pID_i = '0;
    b32.rs1ReadData_i = '0; b32.rs2ReadData_i = '0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.valid_o", b64.valid_o, 0);
    chk("reset.rdAddr_o", b64.rdAddr_o, 0);
    chk("reset.imm_o", b64.imm_o, 0);
    chk("reset.illegal_o", b64.illegal_o, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset.ready_o", b64.ready_o, 1);
    chk("post_reset.valid_o", b64.valid_o, 0);
    @(posedge clk); #1;

    // addi latency: visible one cycle after accept
    issue64(vt[0], 2'd1);
    b64.valid_i = 0;
    @(negedge clk);
    chk("addi.latency_valid_o", b64.valid_o, 1);
    @(posedge clk); #1;

    // Full decode sweep, back-to-back, expecting one output per cycle
    base = pop64.size();
    for (int i = 1; i < 15; i++) issue64(vt[i], i[1:0]);
    b64.valid_i = 0;
    repeat (3) @(negedge clk);
    chk("sweep.count", pop64.size() - base, 14);
    for (int k = base + 1; k < pop64.size(); k++) chk("sweep.gap", pop64[k] - pop64[k-1], 1);
    @(posedge clk); #1;

    // Stall: first in main, second in skid, then drain with a third
    b64.ready_i = 0;
    issue64(vt[0], 2'd0);
    issue64(vt[4], 2'd1);
    b64.valid_i = 0;
    @(negedge clk);
    chk("stall.ready_o", b64.ready_o, 0);
    chk("stall.valid_o", b64.valid_o, 1);
    chk("stall.head_rd", b64.rdAddr_o, 5);
    @(posedge clk); #1;
    b64.ready_i = 1;
    base = pop64.size();
    issue64(vt[7], 2'd2);
    b64.valid_i = 0;
    repeat (3) @(negedge clk);
    chk("stall.count", pop64.size() - base, 3);
    for (int k = base + 1; k < pop64.size(); k++) chk("stall.gap", pop64[k] - pop64[k-1], 1);
    @(posedge clk); #1;

    // Flush with both registers full and an input presented
    b64.ready_i = 0;
    issue64(vt[2], 2'd0);
    issue64(vt[5], 2'd1);
    chk("flush_full.qdepth", q64.size(), 2);
    q64.delete();
    b64.flush_i = 1; b64.inst_i = vt[8].inst;
    @(posedge clk); #1;
    b64.flush_i = 0; b64.valid_i = 0;
    @(negedge clk);
    chk("flush_full.valid_o", b64.valid_o, 0);
    chk("flush_full.ready_o", b64.ready_o, 1);
    @(posedge clk); #1;

    // Flush while ready_o=1: the presented input must be dropped, not captured
    issue64(vt[3], 2'd2);
    q64.delete();
    b64.flush_i = 1; b64.inst_i = vt[10].inst;
    @(posedge clk); #1;
    b64.flush_i = 0; b64.valid_i = 0;
    @(negedge clk);
    chk("flush_open.valid_o", b64.valid_o, 0);
    @(posedge clk); #1;
    b64.ready_i = 1;
    repeat (3) @(posedge clk); #1;
    issue64(vt[9], 2'd3);
    b64.valid_i = 0;
    repeat (2) @(posedge clk); #1;

    // Reset mid-transfer discards the held bundle and zeroes payload outputs
    b64.ready_i = 0;
    issue64(vt[12], 2'd1);
    b64.valid_i = 0;
    q64.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midreset.valid_o", b64.valid_o, 0);
    chk("midreset.rdAddr_o", b64.rdAddr_o, 0);
    chk("midreset.imm_o", b64.imm_o, 0);
    chk("midreset.shamt_o", b64.shamt_o, 0);
    chk("midreset.ready_o", b64.ready_o, 1);
    @(posedge clk); #1;
    b64.ready_i = 1;
    issue64(vt[13], 2'd2);
    b64.valid_i = 0;

    // RV32 / RV64 disabled instance
    for (int i = 0; i < 5; i++) issue32(wt[i], i[1:0]);
    b32.valid_i = 0;

    t = 0;
    while ((q64.size() != 0 || q32.size() != 0) && t < 20) begin @(posedge clk); t++; end
    @(negedge clk);
    chk("drain.q64", q64.size(), 0);
    chk("drain.q32", q32.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
